mem_burst_ctrl: RTL and testbench

- Burst access controller directly upstream of the single-port calculator memory. Drives its Din/Addr/R_W/Valid inputs and consumes its Dout.
- Accepts one command at a time (start address, beat count, direction) via valid/ready.
- Write bursts: streams write beats into memory.
- Read bursts: returns memory data on a backpressured read stream; a 2-entry buffer absorbs the memory's 1-cycle read latency.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/rd_skid_fifo.sv | 42 ++++
 rtl/mem_burst_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the calculator-memory burst controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR    = 2'd1,
      RD    = 2'd2,
      FLUSH = 2'd3
   } state_e;

   localparam logic RW_WRITE     = 1'b1;
   localparam logic RW_READ      = 1'b0;
   localparam int   RD_BUF_DEPTH = 2;

endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry read-return buffer absorbing the memory's one-cycle read latency.
module rd_skid_fifo
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] pop_data_o,
   output logic [1:0]        occ_o
);

   // Single-bit pointers: depth is fixed at two entries.
   logic [DATA_W-1:0] mem_q [RD_BUF_DEPTH];
   logic              wptr_q, rptr_q;
   logic [1:0]        occ_q, occ_d;

   assign occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < RD_BUF_DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         occ_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wptr_q] <= push_data_i;
            wptr_q        <= ~wptr_q;
         end
         if (pop_i) rptr_q <= ~rptr_q;
         occ_q <= occ_d;
      end
   end

   assign pop_data_o = mem_q[rptr_q];
   assign occ_o      = occ_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst front-end for the single-port calculator memory.
// Build option BOUNDARY_CHECK_EN rejects bursts that would run past the top address.
module mem_burst_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Cmd_Valid,
   output logic              Cmd_Ready,
   input  logic              Cmd_RW,
   input  logic [ADDR_W-1:0] Cmd_Addr,
   input  logic [LEN_W-1:0]  Cmd_Len,
   input  logic [DATA_W-1:0] Wr_Data,
   input  logic              Wr_Valid,
   output logic              Wr_Ready,
   output logic [DATA_W-1:0] Rd_Data,
   output logic              Rd_Valid,
   input  logic              Rd_Ready,
   output logic [DATA_W-1:0] Mem_Din,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic              Mem_R_W,
   output logic              Mem_Valid,
   input  logic [DATA_W-1:0] Mem_Dout,
   output logic              Busy,
   output logic              Done,
   output logic              Err
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [LEN_W:0]    BEAT_ONE = 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d, maddr_q;
   logic [LEN_W:0]    beats_q, beats_d;
   logic [DATA_W-1:0] mdin_q, fifo_data;
   logic [1:0]        occ;
   logic              inflight_q, done_q, done_d, mrw_q;
   logic              cmd_rdy, wr_rdy, rd_vld, pop, room, wr_beat, issue, mem_vld;

   assign cmd_rdy = (state_q == IDLE) && !Reset;
   assign wr_rdy  = (state_q == WR) && !Reset;
   assign rd_vld  = (occ != 2'd0) && !Reset;
   assign pop     = rd_vld && Rd_Ready;
   // A pop frees a slot in the same cycle, which keeps reads at one per cycle.
   assign room    = (({1'b0, occ} + {2'b00, inflight_q}) < 3'(RD_BUF_DEPTH)) || pop;

`ifdef BOUNDARY_CHECK_EN
   logic [ADDR_W+LEN_W:0] bnd_sum;
   logic                  bnd_ovf, err_q, err_d;
   assign bnd_sum = {{(LEN_W+1){1'b0}}, Cmd_Addr} + {{(ADDR_W+1){1'b0}}, Cmd_Len};
   assign bnd_ovf = |bnd_sum[ADDR_W+LEN_W:ADDR_W];
`endif

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      beats_d = beats_q;
      done_d  = 1'b0;
      wr_beat = 1'b0;
      issue   = 1'b0;
`ifdef BOUNDARY_CHECK_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (Cmd_Valid && cmd_rdy) begin
               cur_d   = Cmd_Addr;
               beats_d = {1'b0, Cmd_Len} + BEAT_ONE;
`ifdef BOUNDARY_CHECK_EN
               if (bnd_ovf) err_d = 1'b1;
               else         state_d = (Cmd_RW == RW_WRITE) ? WR : RD;
`else
               state_d = (Cmd_RW == RW_WRITE) ? WR : RD;
`endif
            end
         end
         WR: begin
            if (Wr_Valid && wr_rdy) begin
               wr_beat = 1'b1;
               cur_d   = cur_q + ADDR_ONE;
               beats_d = beats_q - BEAT_ONE;
               if (beats_q == BEAT_ONE) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         RD: begin
            if (room && !Reset) begin
               issue   = 1'b1;
               cur_d   = cur_q + ADDR_ONE;
               beats_d = beats_q - BEAT_ONE;
               if (beats_q == BEAT_ONE) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (!inflight_q && (occ == 2'd0)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         beats_q    <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         maddr_q    <= '0;
         mrw_q      <= RW_READ;
         mdin_q     <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         beats_q    <= beats_d;
         inflight_q <= issue;
         done_q     <= done_d;
         if (mem_vld) begin
            maddr_q <= cur_q;
            mrw_q   <= wr_beat ? RW_WRITE : RW_READ;
         end
         if (wr_beat) mdin_q <= Wr_Data;
      end
   end

`ifdef BOUNDARY_CHECK_EN
   always_ff @(posedge Clk) begin
      if (Reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end
   assign Err = err_q;
`else
   assign Err = 1'b0;
`endif

   // Memory data returns the cycle after an issue, so inflight_q doubles as the push strobe.
   rd_skid_fifo #(.DATA_W(DATA_W)) u_rd_fifo (
      .clk_i       (Clk),
      .reset_i     (Reset),
      .push_i      (inflight_q),
      .push_data_i (Mem_Dout),
      .pop_i       (pop),
      .pop_data_o  (fifo_data),
      .occ_o       (occ)
   );

   assign mem_vld   = wr_beat || issue;
   assign Mem_Valid = mem_vld;
   assign Mem_R_W   = Reset ? RW_READ : (mem_vld ? (wr_beat ? RW_WRITE : RW_READ) : mrw_q);
   assign Mem_Addr  = Reset ? '0 : (mem_vld ? cur_q : maddr_q);
   assign Mem_Din   = Reset ? '0 : (wr_beat ? Wr_Data : mdin_q);
   assign Cmd_Ready = cmd_rdy;
   assign Wr_Ready  = wr_rdy;
   assign Rd_Valid  = rd_vld;
   assign Rd_Data   = fifo_data;
   assign Busy      = (state_q != IDLE);
   assign Done      = done_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: behavioural memory, bus monitor and randomized burst traffic.
module tb_mem_burst_ctrl;

   logic        Clk = 1'b0, Reset = 1'b1;
   logic        Cmd_Valid = 1'b0, Cmd_RW = 1'b0, Wr_Valid = 1'b0, Rd_Ready = 1'b0;
   logic [7:0]  Cmd_Addr = '0, Cmd_Len = '0;
   logic [31:0] Wr_Data = '0, Mem_Dout = '0;
   logic        Cmd_Ready, Wr_Ready, Rd_Valid, Mem_R_W, Mem_Valid, Busy, Done, Err;
   logic [31:0] Rd_Data, Mem_Din;
   logic [7:0]  Mem_Addr;

   always #5 Clk = ~Clk;

   mem_burst_ctrl #(.ADDR_W(8), .DATA_W(32), .LEN_W(8)) dut (
      .Clk(Clk), .Reset(Reset), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_RW(Cmd_RW),
      .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len), .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid),
      .Wr_Ready(Wr_Ready), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready),
      .Mem_Din(Mem_Din), .Mem_Addr(Mem_Addr), .Mem_R_W(Mem_R_W), .Mem_Valid(Mem_Valid),
      .Mem_Dout(Mem_Dout), .Busy(Busy), .Done(Done), .Err(Err)
   );

   // Single-port memory with one-cycle read latency.
   logic [31:0] tmem [256] = '{default: 32'h0};
   always @(posedge Clk)
      if (Mem_Valid) begin
         if (Mem_R_W) tmem[Mem_Addr] <= Mem_Din;
         else         Mem_Dout <= tmem[Mem_Addr];
      end

   logic [31:0] ref_mem [256] = '{default: 32'h0};
   logic [31:0] wdata [256];
   int total = 0, bad = 0, cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] a; logic rw; logic [31:0] d; int c; } acc_t;
   typedef struct { logic [31:0] d; int c; } rd_t;
   acc_t acc_q[$];
   rd_t  rd_q[$];
   int done_cnt, err_cnt, done_cyc, first_issue, first_rv, outstanding, max_out, stall_bad;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   always begin
      @(negedge Clk); #2;
      if (Reset) begin
         prev_stall  = 1'b0;
         outstanding = 0;
      end else begin
         if (Mem_Valid) begin
            acc_q.push_back('{Mem_Addr, Mem_R_W, Mem_Din, cyc});
            if (!Mem_R_W) begin
               if (first_issue < 0) first_issue = cyc;
               outstanding++;
            end
         end
         if (Rd_Valid && first_rv < 0) first_rv = cyc;
         if (prev_stall && (!Rd_Valid || Rd_Data !== prev_data)) stall_bad++;
         if (Rd_Valid && Rd_Ready) begin
            rd_q.push_back('{Rd_Data, cyc});
            outstanding--;
         end
         if (outstanding > max_out) max_out = outstanding;
         prev_stall = Rd_Valid && !Rd_Ready;
         prev_data  = Rd_Data;
         if (Done) begin done_cnt++; done_cyc = cyc; end
         if (Err) err_cnt++;
      end
   end

   task automatic clear_mon();
      acc_q.delete(); rd_q.delete();
      done_cnt = 0; err_cnt = 0; done_cyc = -1; first_issue = -1; first_rv = -1;
      max_out = 0; stall_bad = 0;
   endtask

   task automatic send_cmd(input logic rw, input logic [7:0] a, input logic [7:0] len, output bit ok);
      Cmd_Valid = 1'b1; Cmd_RW = rw; Cmd_Addr = a; Cmd_Len = len; ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1; ok = Cmd_Ready;
         @(negedge Clk);
      end
      Cmd_Valid = 1'b0;
   endtask

   task automatic write_beats(input int n, input bit gaps, output bit ok);
      int idx = 0;
      for (int i = 0; i < 400 && idx < n; i++) begin
         Wr_Valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         Wr_Data  = wdata[idx];
         #1; if (Wr_Valid && Wr_Ready) idx++;
         @(negedge Clk);
      end
      Wr_Valid = 1'b0;
      ok = (idx == n);
   endtask

   task automatic read_beats(input int n, input int mode, output bit ok);
      for (int k = 0; k < 400 && rd_q.size() < n; k++) begin
         case (mode)
            0:       Rd_Ready = 1'b1;
            1:       Rd_Ready = (k % 4 == 0) || (k % 4 == 3);
            default: Rd_Ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge Clk);
      end
      Rd_Ready = 1'b0;
      ok = (rd_q.size() == n);
   endtask

   task automatic wait_done(input int start, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         #3; ok = (done_cnt > start);
         @(negedge Clk);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v [11];
      Reset = 1'b1;
      @(negedge Clk); @(negedge Clk); #1;
      v = '{32'(Cmd_Ready), 32'(Wr_Ready), 32'(Rd_Valid), 32'(Mem_Valid), 32'(Busy),
            32'(Done), 32'(Err), Rd_Data, Mem_Din, 32'(Mem_Addr), 32'(Mem_R_W)};
      for (int i = 0; i < 11; i++) begin
         total++;
         if (v[i] !== 32'h0) begin bad++; $display("FAIL reset_out[%0d]: got %h want 0", i, v[i]); end
      end
      @(negedge Clk); Reset = 1'b0;
      @(negedge Clk); #1;
      total++;
      if (Cmd_Ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", Cmd_Ready); end
      @(negedge Clk);
   endtask

   task automatic test_write();
      bit ok1, ok2, ok3;
      clear_mon();
      for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
      send_cmd(1'b1, 8'h10, 8'd3, ok1);
      write_beats(4, 1'b0, ok2);
      wait_done(0, ok3);
      for (int i = 0; i < 4; i++) ref_mem[8'h10 + i] = wdata[i];
      total++;
      if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL wr_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
      total++;
      if (acc_q.size() != 4) begin bad++; $display("FAIL wr_count: got %0d want 4", acc_q.size()); end
      for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
         total++;
         if (acc_q[i].a !== 8'(8'h10 + i) || acc_q[i].rw !== 1'b1 || acc_q[i].d !== wdata[i] ||
             acc_q[i].c != acc_q[0].c + i) begin
            bad++;
            $display("FAIL wr_beat[%0d]: got a=%h rw=%b d=%h c=%0d want a=%h rw=1 d=%h c=%0d", i,
                     acc_q[i].a, acc_q[i].rw, acc_q[i].d, acc_q[i].c, 8'(8'h10 + i), wdata[i], acc_q[0].c + i);
         end
      end
      total++;
      if (done_cnt != 1 || acc_q.size() != 4 || done_cyc != acc_q[3].c + 1) begin
         bad++; $display("FAIL wr_done: got cnt=%0d cyc=%0d want cnt=1 one cycle after last beat", done_cnt, done_cyc);
      end
   endtask

   task automatic test_read();
      bit ok1, ok2, ok3;
      clear_mon();
      send_cmd(1'b0, 8'h10, 8'd3, ok1);
      read_beats(4, 0, ok2);
      wait_done(0, ok3);
      total++;
      if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL rd_timeout: got %b%b%b want 111", ok1, ok2, ok3); end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i].d !== ref_mem[8'h10 + i] || rd_q[i].c != rd_q[0].c + i) begin
            bad++; $display("FAIL rd_beat[%0d]: got d=%h c=%0d want d=%h c=%0d", i, rd_q[i].d, rd_q[i].c,
                            ref_mem[8'h10 + i], rd_q[0].c + i);
         end
      end
      total++;
      if (first_rv != first_issue + 2) begin
         bad++; $display("FAIL rd_latency: got first valid %0d want %0d", first_rv, first_issue + 2);
      end
      total++;
      if (acc_q.size() != 4 || done_cnt != 1 || Busy !== 1'b0) begin
         bad++; $display("FAIL rd_issue_done: got issues=%0d done=%0d busy=%b want 4 1 0", acc_q.size(), done_cnt, Busy);
      end
   endtask

   task automatic test_read_stall();
      bit ok1, ok2, ok3;
      clear_mon();
      send_cmd(1'b0, 8'h10, 8'd3, ok1);
      read_beats(4, 1, ok2);
      wait_done(0, ok3);
      total++;
      if (!(ok1 && ok2 && ok3) || rd_q.size() != 4) begin
         bad++; $display("FAIL stall_timeout: got %b%b%b beats=%0d want 111 4", ok1, ok2, ok3, rd_q.size());
      end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i].d !== ref_mem[8'h10 + i]) begin
            bad++; $display("FAIL stall_beat[%0d]: got %h want %h", i, rd_q[i].d, ref_mem[8'h10 + i]);
         end
      end
      total++;
      if (stall_bad != 0 || max_out > 2) begin
         bad++; $display("FAIL stall_hold: got unstable=%0d outstanding=%0d want 0 <=2", stall_bad, max_out);
      end
   endtask

   task automatic test_wrap();
      bit ok1, ok2, ok3;
      clear_mon();
      for (int i = 0; i < 3; i++) wdata[i] = 32'hC0 + 32'(i);
      send_cmd(1'b1, 8'hFE, 8'd2, ok1);
`ifdef BOUNDARY_CHECK_EN
      repeat (3) @(negedge Clk);
      total++;
      if (!ok1 || err_cnt != 1 || acc_q.size() != 0 || done_cnt != 0 || Busy !== 1'b0) begin
         bad++; $display("FAIL bnd_reject: got err=%0d acc=%0d done=%0d busy=%b want 1 0 0 0",
                         err_cnt, acc_q.size(), done_cnt, Busy);
      end
`else
      write_beats(3, 1'b0, ok2);
      wait_done(0, ok3);
      for (int i = 0; i < 3; i++) ref_mem[8'(8'hFE + i)] = wdata[i];
      total++;
      if (!(ok1 && ok2 && ok3) || acc_q.size() != 3 || err_cnt != 0) begin
         bad++; $display("FAIL wrap_run: got ok=%b%b%b acc=%0d err=%0d want 111 3 0", ok1, ok2, ok3, acc_q.size(), err_cnt);
      end
      for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
         total++;
         if (acc_q[i].a !== 8'(8'hFE + i) || acc_q[i].d !== wdata[i]) begin
            bad++; $display("FAIL wrap_addr[%0d]: got %h/%h want %h/%h", i, acc_q[i].a, acc_q[i].d, 8'(8'hFE + i), wdata[i]);
         end
      end
`endif
   endtask

   task automatic test_reset_mid();
      bit ok1;
      logic [31:0] v [5];
      clear_mon();
      send_cmd(1'b0, 8'h10, 8'd7, ok1);
      for (int k = 0; k < 100 && rd_q.size() < 2; k++) begin
         Rd_Ready = 1'b1;
         @(negedge Clk);
      end
      total++;
      if (!ok1 || rd_q.size() != 2 || rd_q[0].d !== ref_mem[8'h10] || rd_q[1].d !== ref_mem[8'h11]) begin
         bad++; $display("FAIL rstmid_pre: got beats=%0d want 2 matching memory", rd_q.size());
      end
      Reset = 1'b1;
      @(negedge Clk); #1;
      v = '{32'(Busy), 32'(Rd_Valid), 32'(Mem_Valid), 32'(Cmd_Ready), 32'(Done)};
      for (int i = 0; i < 5; i++) begin
         total++;
         if (v[i] !== 32'h0) begin bad++; $display("FAIL rstmid_out[%0d]: got %h want 0", i, v[i]); end
      end
      Reset = 1'b0; Rd_Ready = 1'b0;
      @(negedge Clk); #1;
      total++;
      if (Cmd_Ready !== 1'b1 || Busy !== 1'b0 || Rd_Valid !== 1'b0) begin
         bad++; $display("FAIL rstmid_release: got rdy=%b busy=%b rv=%b want 1 0 0", Cmd_Ready, Busy, Rd_Valid);
      end
      @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2, ok3, ok4;
      logic dn, rdy;
      clear_mon();
      wdata[0] = 32'h11;
      send_cmd(1'b1, 8'h40, 8'd0, ok1);
      write_beats(1, 1'b0, ok2);
      Cmd_Valid = 1'b1; Cmd_RW = 1'b1; Cmd_Addr = 8'h41; Cmd_Len = 8'd0;
      #1; dn = Done; rdy = Cmd_Ready;
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      wdata[0] = 32'h22;
      write_beats(1, 1'b0, ok3);
      wait_done(1, ok4);
      ref_mem[8'h40] = 32'h11; ref_mem[8'h41] = 32'h22;
      total++;
      if (dn !== 1'b1 || rdy !== 1'b1) begin
         bad++; $display("FAIL b2b_accept: got done=%b ready=%b want 1 1", dn, rdy);
      end
      total++;
      if (!(ok1 && ok2 && ok3 && ok4) || done_cnt != 2 || acc_q.size() != 2) begin
         bad++; $display("FAIL b2b_done: got done=%0d acc=%0d want 2 2", done_cnt, acc_q.size());
      end else begin
         total++;
         if (acc_q[0].a !== 8'h40 || acc_q[0].d !== 32'h11 || acc_q[1].a !== 8'h41 || acc_q[1].d !== 32'h22) begin
            bad++; $display("FAIL b2b_data: got %h/%h %h/%h want 40/11 41/22",
                            acc_q[0].a, acc_q[0].d, acc_q[1].a, acc_q[1].d);
         end
      end
   endtask

   task automatic test_random();
      bit ok1, ok2, ok3;
      int len, a;
      for (int it = 0; it < 8; it++) begin
         clear_mon();
         len = $urandom_range(0, 7);
         a   = $urandom_range(0, 255 - len);
         for (int i = 0; i <= len; i++) wdata[i] = $urandom();
         send_cmd(1'b1, 8'(a), 8'(len), ok1);
         write_beats(len + 1, 1'b1, ok2);
         wait_done(0, ok3);
         for (int i = 0; i <= len; i++) ref_mem[a + i] = wdata[i];
         total++;
         if (!(ok1 && ok2 && ok3) || acc_q.size() != len + 1) begin
            bad++; $display("FAIL rnd_wr[%0d]: got acc=%0d want %0d", it, acc_q.size(), len + 1);
         end
         clear_mon();
         len = $urandom_range(0, 9);
         if (it % 2 == 0) a = $urandom_range(0, 255 - len);
         else if (a > 255 - len) a = 255 - len;
         send_cmd(1'b0, 8'(a), 8'(len), ok1);
         read_beats(len + 1, 2, ok2);
         wait_done(0, ok3);
         total++;
         if (!(ok1 && ok2 && ok3) || stall_bad != 0 || max_out > 2) begin
            bad++; $display("FAIL rnd_rd[%0d]: got beats=%0d unstable=%0d outstanding=%0d", it, rd_q.size(), stall_bad, max_out);
         end
         for (int i = 0; i < rd_q.size(); i++) begin
            total++;
            if (rd_q[i].d !== ref_mem[a + i]) begin
               bad++; $display("FAIL rnd_beat[%0d.%0d]: got %h want %h", it, i, rd_q[i].d, ref_mem[a + i]);
            end
         end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_write();
      test_read();
      test_read_stall();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
